// File: rtl/gauss_blur_seq.sv
// gauss_blur_seq: frame sequencer for the two-stage 3x3 Gaussian blur datapath.
//
// Takes a raster-order 8-bit pixel stream, keeps the two previous lines in
// on-chip line buffers and presents every interior 3x3 window to the external
// datapath. A valid/coordinate pipe matching the datapath latency tags each
// returned result. Only interior windows are produced, so the output image
// is (IMG_W-2) x (IMG_H-2).
//
// Ports:
//   clk, Reset        clock (rising edge), asynchronous active-high reset
//   start             one-cycle pulse that begins a frame; used only in IDLE
//   in_valid/in_ready input pixel handshake
//   in_pixel          raster-order input pixel
//   win_pixels        window to datapath, [8k+7:8k] = input_pixel_(k+1)
//   win_valid         one-cycle strobe: win_pixels holds a new window
//   dp_value          datapath result, DP_LAT edges after win_valid
//   out_value         blurred pixel (0 when out_valid is low)
//   out_valid         one-cycle strobe per result
//   out_row, out_col  top-left coordinate of the window the result belongs to
//   busy              high from STREAM entry until frame_done
//   frame_done        one-cycle pulse one cycle after the last out_valid
//
// Handshake: a pixel transfers on a rising edge where in_valid and in_ready
// are both high; in_ready depends only on the state, never on in_valid, and
// pixels offered while in_ready is low are dropped. The result side has no
// backpressure: every out_valid strobe must be taken by the consumer.
module gauss_blur_seq #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int DP_LAT = 2
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_pixel,
  output logic        in_ready,
  output logic [71:0] win_pixels,
  output logic        win_valid,
  input  logic [7:0]  dp_value,
  output logic [7:0]  out_value,
  output logic        out_valid,
  output logic [9:0]  out_row,
  output logic [9:0]  out_col,
  output logic        busy,
  output logic        frame_done
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int DW = $clog2(DP_LAT + 1) + 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DP_LAT);
  localparam logic [9:0] X_LAST = 10'(IMG_W - 1);
  localparam logic [9:0] Y_LAST = 10'(IMG_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

  state_t state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic frame_done_q, frame_done_d;

  logic [9:0] x_q, x_d, y_q, y_d;
  logic [23:0] col_q [3];
  logic [23:0] col_d [3];
  logic win_valid_q, win_valid_d;
  logic [9:0] win_row_q, win_row_d, win_col_q, win_col_d;
  logic [DP_LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic [DP_LAT-1:0][9:0] row_pipe_q, row_pipe_d, col_pipe_q, col_pipe_d;

  // Line buffers: lb1 holds row y-1, lb2 holds row y-2. No reset needed.
  logic [7:0] lb1_q [IMG_W];
  logic [7:0] lb2_q [IMG_W];

  logic accept;
  logic last_accept;
  logic [AW-1:0] xi;
  logic [23:0] new_col;

  assign xi          = x_q[AW-1:0];
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (x_q == X_LAST) && (y_q == Y_LAST);
  // Column layout: [23:16] = row y-2 (top), [15:8] = row y-1, [7:0] = row y.
  assign new_col     = {lb2_q[xi], lb1_q[xi], in_pixel};

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_STREAM;
      S_STREAM: if (last_accept) state_d = S_DRAIN;
      S_DRAIN:  if (drain_q == DRAIN_LAST) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // DRAIN runs until the last window has come back from the datapath and its
  // strobe has been issued; frame_done lands on the cycle after that strobe.
  always_comb begin
    in_ready     = (state_q == S_STREAM);
    busy         = (state_q != S_IDLE);
    frame_done_d = (state_q == S_DRAIN) && (drain_q == DRAIN_LAST);
    drain_d      = (state_q == S_DRAIN) ? drain_q + DW'(1) : '0;
  end

  // ---------------- position, window and latency pipe ----------------
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if ((state_q == S_IDLE) && start) begin
      x_d = '0;
      y_d = '0;
    end else if (accept) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end

    for (int i = 0; i < 3; i++) col_d[i] = col_q[i];
    if (accept) begin
      col_d[0] = col_q[1];
      col_d[1] = col_q[2];
      col_d[2] = new_col;
    end

    // The x >= 2 test keeps stale columns from the previous line out.
    win_valid_d = accept && (x_q >= 10'd2) && (y_q >= 10'd2);
    win_row_d   = win_valid_d ? y_q - 10'd2 : '0;
    win_col_d   = win_valid_d ? x_q - 10'd2 : '0;

    vld_pipe_d    = vld_pipe_q;
    row_pipe_d    = row_pipe_q;
    col_pipe_d    = col_pipe_q;
    vld_pipe_d[0] = win_valid_q;
    row_pipe_d[0] = win_row_q;
    col_pipe_d[0] = win_col_q;
    for (int i = 1; i < DP_LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      row_pipe_d[i] = row_pipe_q[i-1];
      col_pipe_d[i] = col_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      drain_q      <= '0;
      frame_done_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      for (int i = 0; i < 3; i++) col_q[i] <= '0;
      win_valid_q  <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      vld_pipe_q   <= '0;
      row_pipe_q   <= '0;
      col_pipe_q   <= '0;
    end else begin
      drain_q      <= drain_d;
      frame_done_q <= frame_done_d;
      x_q          <= x_d;
      y_q          <= y_d;
      for (int i = 0; i < 3; i++) col_q[i] <= col_d[i];
      win_valid_q  <= win_valid_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      vld_pipe_q   <= vld_pipe_d;
      row_pipe_q   <= row_pipe_d;
      col_pipe_q   <= col_pipe_d;
    end
  end

  // Read-before-write: the column read above sees the old contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2_q[xi] <= lb1_q[xi];
      lb1_q[xi] <= in_pixel;
    end
  end

  // p1..p3 = top row, p4..p6 = middle, p7..p9 = bottom; col_q[0] is column x-2.
  assign win_pixels = {col_q[2][7:0],   col_q[1][7:0],   col_q[0][7:0],
                       col_q[2][15:8],  col_q[1][15:8],  col_q[0][15:8],
                       col_q[2][23:16], col_q[1][23:16], col_q[0][23:16]};
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign out_valid  = vld_pipe_q[DP_LAT-1];
  assign out_value  = out_valid ? dp_value : 8'd0;
  assign out_row    = out_valid ? row_pipe_q[DP_LAT-1] : 10'd0;
  assign out_col    = out_valid ? col_pipe_q[DP_LAT-1] : 10'd0;

endmodule

// File: tb/tb_gauss_blur_seq.sv
// tb_gauss_blur_seq: directed bench for gauss_blur_seq.
// Instance A is a 5x4 frame sequencer, instance B a 5x5 one. Each is paired
// with a two-register Gaussian datapath model (weights 16/32/64, sum 256).
module tb_gauss_blur_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- DUT A (5x4) ----------------
  logic        start_a, in_valid_a, in_ready_a, win_valid_a, out_valid_a, busy_a, frame_done_a;
  logic [7:0]  in_pixel_a, dp_value_a, out_value_a, dp1_a;
  logic [71:0] win_pixels_a;
  logic [9:0]  out_row_a, out_col_a;

  gauss_blur_seq #(.IMG_W(5), .IMG_H(4), .DP_LAT(2)) dut_a (
    .clk(clk), .Reset(rst), .start(start_a), .in_valid(in_valid_a), .in_pixel(in_pixel_a),
    .in_ready(in_ready_a), .win_pixels(win_pixels_a), .win_valid(win_valid_a),
    .dp_value(dp_value_a), .out_value(out_value_a), .out_valid(out_valid_a),
    .out_row(out_row_a), .out_col(out_col_a), .busy(busy_a), .frame_done(frame_done_a)
  );

  // ---------------- DUT B (5x5) ----------------
  logic        start_b, in_valid_b, in_ready_b, win_valid_b, out_valid_b, busy_b, frame_done_b;
  logic [7:0]  in_pixel_b, dp_value_b, out_value_b, dp1_b;
  logic [71:0] win_pixels_b;
  logic [9:0]  out_row_b, out_col_b;

  gauss_blur_seq #(.IMG_W(5), .IMG_H(5), .DP_LAT(2)) dut_b (
    .clk(clk), .Reset(rst), .start(start_b), .in_valid(in_valid_b), .in_pixel(in_pixel_b),
    .in_ready(in_ready_b), .win_pixels(win_pixels_b), .win_valid(win_valid_b),
    .dp_value(dp_value_b), .out_value(out_value_b), .out_valid(out_valid_b),
    .out_row(out_row_b), .out_col(out_col_b), .busy(busy_b), .frame_done(frame_done_b)
  );

  // ---------------- datapath model: multiply register, adder register ----------------
  function automatic logic [7:0] gauss(input logic [71:0] w);
    int s;
    int wt [9];
    wt = '{16, 32, 16, 32, 64, 32, 16, 32, 16};
    s = 0;
    for (int k = 0; k < 9; k++) s += wt[k] * int'(w[8*k +: 8]);
    return 8'(s >> 8);
  endfunction

  always @(posedge clk) begin
    dp1_a      <= gauss(win_pixels_a);
    dp_value_a <= dp1_a;
    dp1_b      <= gauss(win_pixels_b);
    dp_value_b <= dp1_b;
  end

  // ---------------- scoreboard / monitors ----------------
  typedef struct { logic [9:0] row; logic [9:0] col; logic [7:0] val; } res_t;
  typedef struct { logic [9:0] row; logic [9:0] col; } coord_t;
  typedef struct { logic [7:0] fill; bit gap; bit extra_start; int exp_rdy; int exp_busy; } frame_vec_t;

  res_t obs_a[$];
  res_t obs_b[$];
  int acc_a = 0, rdy_a = 0, busy_cnt_a = 0, fd_cnt_a = 0, fd_cyc_a = 0, last_ov_a = 0;
  int early_a = 0, acc_mark = 0;

  always @(negedge clk) begin
    res_t r;
    if (out_valid_a) begin
      r.row = out_row_a; r.col = out_col_a; r.val = out_value_a;
      obs_a.push_back(r);
      last_ov_a = cyc;
      if (acc_a - acc_mark < 13) early_a++;
    end
    if (in_valid_a && in_ready_a) acc_a++;
    if (in_ready_a) rdy_a++;
    if (busy_a) busy_cnt_a++;
    if (frame_done_a) begin fd_cnt_a++; fd_cyc_a = cyc; end
    if (out_valid_b) begin
      r.row = out_row_b; r.col = out_col_b; r.val = out_value_b;
      obs_b.push_back(r);
    end
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  coord_t const_tbl [6];
  res_t   imp_tbl [9];
  frame_vec_t fv [5];
  logic [7:0] img [25];

  task automatic check_const(input string tag, input logic [7:0] fill);
    res_t o;
    check({tag, ".count"}, obs_a.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (obs_a.size() == 0) break;
      o = obs_a.pop_front();
      check({tag, ".row"}, o.row, const_tbl[i].row);
      check({tag, ".col"}, o.col, const_tbl[i].col);
      check({tag, ".val"}, o.val, fill);
    end
    obs_a.delete();
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, ".in_ready"}, in_ready_a, 0);
    check({tag, ".busy"}, busy_a, 0);
    check({tag, ".win_valid"}, win_valid_a, 0);
    check({tag, ".win_pixels_zero"}, (win_pixels_a == 72'd0), 1);
    check({tag, ".out_valid"}, out_valid_a, 0);
    check({tag, ".out_value"}, out_value_a, 0);
    check({tag, ".out_row"}, out_row_a, 0);
    check({tag, ".out_col"}, out_col_a, 0);
    check({tag, ".frame_done"}, frame_done_a, 0);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit sel, input logic s, input logic v, input logic [7:0] p);
    if (sel) begin start_b = s; in_valid_b = v; in_pixel_b = p; end
    else     begin start_a = s; in_valid_a = v; in_pixel_a = p; end
  endtask

  function automatic logic rdy_of(input bit sel);
    return sel ? in_ready_b : in_ready_a;
  endfunction

  // Starts a frame, streams img[0..n_pix-1], optionally pulses start mid-stream
  // and in DRAIN, then waits (bounded) for frame_done.
  task automatic run_frame(input bit sel, input int n_pix, input bit gap,
                           input bit extra_start, input bit stop_after10);
    int idx, guard, g;
    bit tog, xs_done, s;
    logic v, r, seen;
    idx = 0; guard = 0; tog = 0; xs_done = 0;
    @(posedge clk); #1 drive(sel, 1'b1, 1'b0, 8'd0);
    @(posedge clk); #1;
    while (idx < n_pix && guard < 500) begin
      v = gap ? ~tog : 1'b1;
      tog = ~tog;
      s = extra_start && (idx == 7) && !xs_done;
      if (s) xs_done = 1;
      drive(sel, s, v, img[idx]);
      r = rdy_of(sel);
      @(posedge clk); #1;
      if (v && r) idx++;
      guard++;
      if (stop_after10 && idx == 10) break;
    end
    if (stop_after10) return;
    drive(sel, 1'b0, 1'b0, 8'd0);
    check("stream_complete", idx, n_pix);
    if (extra_start) begin
      drive(sel, 1'b1, 1'b0, 8'd0);
      @(posedge clk); #1 drive(sel, 1'b0, 1'b0, 8'd0);
    end
    g = 0; seen = 1'b0;
    while (!seen && g < 60) begin
      @(negedge clk);
      g++;
      seen = sel ? frame_done_b : frame_done_a;
    end
    check("frame_done_seen", seen, 1);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int a0, r0, b0, f0, e0;
    res_t o;

    const_tbl = '{'{10'd0, 10'd0}, '{10'd0, 10'd1}, '{10'd0, 10'd2},
                  '{10'd1, 10'd0}, '{10'd1, 10'd1}, '{10'd1, 10'd2}};
    imp_tbl = '{'{10'd0, 10'd0, 8'd15}, '{10'd0, 10'd1, 8'd31}, '{10'd0, 10'd2, 8'd15},
                '{10'd1, 10'd0, 8'd31}, '{10'd1, 10'd1, 8'd63}, '{10'd1, 10'd2, 8'd31},
                '{10'd2, 10'd0, 8'd15}, '{10'd2, 10'd1, 8'd31}, '{10'd2, 10'd2, 8'd15}};
    // {fill, gap, start in STREAM+DRAIN, in_ready cycles, busy cycles}
    fv = '{'{8'd100, 1'b0, 1'b0, 20, 23},
           '{8'd100, 1'b1, 1'b0, 39, 42},
           '{8'd100, 1'b0, 1'b1, 20, 23},
           '{8'd40,  1'b0, 1'b0, 20, 23},
           '{8'd200, 1'b0, 1'b0, 20, 23}};

    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 8'd0);
    drive(1, 1'b0, 1'b0, 8'd0);
    repeat (3) @(posedge clk);
    #1 check_zero_a("reset");
    rst = 1'b0;

    // in_valid while IDLE must be dropped
    a0 = acc_a;
    in_valid_a = 1'b1; in_pixel_a = 8'd77;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("idle.in_ready", in_ready_a, 0);
      check("idle.busy", busy_a, 0);
    end
    in_valid_a = 1'b0;
    check("idle.accepts", acc_a - a0, 0);

    // constant frames on 5x4, back-to-back (each start the cycle after frame_done)
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 25; i++) img[i] = fv[f].fill;
      a0 = acc_a; r0 = rdy_a; b0 = busy_cnt_a; f0 = fd_cnt_a; e0 = early_a;
      acc_mark = acc_a;
      run_frame(0, 20, fv[f].gap, fv[f].extra_start, 0);
      check_const($sformatf("frame%0d", f), fv[f].fill);
      check("accepts", acc_a - a0, 20);
      check("in_ready_cycles", rdy_a - r0, fv[f].exp_rdy);
      check("busy_cycles", busy_cnt_a - b0, fv[f].exp_busy);
      check("frame_done_count", fd_cnt_a - f0, 1);
      check("frame_done_after_last", fd_cyc_a - last_ov_a, 1);
      check("early_out_valid", early_a - e0, 0);
    end

    // start in DRAIN (frame 2) must leave the sequencer idle afterwards
    repeat (3) @(posedge clk);
    #1;
    check("post_drain_start.busy", busy_a, 0);
    check("post_drain_start.in_ready", in_ready_a, 0);

    // impulse on 5x5
    for (int i = 0; i < 25; i++) img[i] = 8'd0;
    img[12] = 8'd255;
    run_frame(1, 25, 0, 0, 0);
    check("impulse.count", obs_b.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (obs_b.size() == 0) break;
      o = obs_b.pop_front();
      check($sformatf("impulse%0d.row", i), o.row, imp_tbl[i].row);
      check($sformatf("impulse%0d.col", i), o.col, imp_tbl[i].col);
      check($sformatf("impulse%0d.val", i), o.val, imp_tbl[i].val);
    end

    // reset after 10 accepts
    for (int i = 0; i < 25; i++) img[i] = 8'd100;
    a0 = acc_a; f0 = fd_cnt_a;
    obs_a.delete();
    run_frame(0, 20, 0, 0, 1);
    #2 rst = 1'b1;
    #1 check_zero_a("midframe_reset");
    check("midframe_reset.accepts", acc_a - a0, 10);
    @(posedge clk); #1 drive(0, 1'b0, 1'b0, 8'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midframe_reset.no_frame_done", fd_cnt_a - f0, 0);
    check("midframe_reset.no_out_valid", obs_a.size(), 0);
    acc_mark = acc_a; e0 = early_a;
    run_frame(0, 20, 0, 0, 0);
    check_const("after_reset", 8'd100);
    check("after_reset.early_out_valid", early_a - e0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
